// File: rtl/score_pkg.sv
// Shared definitions for the score controller.
//   SCORE_W   : width of the binary score and high-score registers
//   SUM_W     : one extra bit so that the pre-clamp sum cannot wrap
//   MAX_SCORE : saturation ceiling (largest 6-digit BCD value)
//   state_t   : bonus-transfer FSM state encodings
package score_pkg;

  localparam int unsigned SCORE_W   = 24;
  localparam int unsigned SUM_W     = SCORE_W + 1;
  localparam int unsigned MAX_SCORE = 999999;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BONUS = 1'b1
  } state_t;

endpackage

// File: rtl/score_ctl_if.sv
// Game-side bus of the score controller.
//   master : game logic, drives the strobes and observes score/bonus status
//   slave  : score_ctl, consumes the strobes and drives score/bonus status
interface score_ctl_if;
  import score_pkg::*;

  logic               add_en;
  logic [15:0]        add_val;
  logic               level_done;
  logic [7:0]         bonus_time;
  logic               game_over;
  logic               game_clr;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hiscore;
  logic [7:0]         bonus_left;
  logic               bonus_busy;
  logic               bonus_done;

  modport master (
    output add_en, add_val, level_done, bonus_time, game_over, game_clr,
    input  score, hiscore, bonus_left, bonus_busy, bonus_done
  );

  modport slave (
    input  add_en, add_val, level_done, bonus_time, game_over, game_clr,
    output score, hiscore, bonus_left, bonus_busy, bonus_done
  );

endinterface

// File: rtl/score_ctl_tick_gen.sv
// Bonus step timer: counts enabled cycles and asserts tick during the
// TICK_DIV-th consecutive enabled cycle, then restarts.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable (high while a transfer is running)
//   clr        : synchronous clear, wins over en
//   tick       : one-cycle step strobe (combinational from the count)
module tick_gen #(
  parameter int unsigned TICK_DIV = 650000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // Keep at least one counter bit so TICK_DIV == 1 still elaborates.
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr || !en) begin
      cnt_next = '0;
    end else if (cnt_reg == LAST) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = en && !clr && (cnt_reg == LAST);

endmodule

// File: rtl/score_ctl.sv
// Score controller: saturating score accumulator, high-score register and
// time-bonus transfer FSM that drains bonus_time into the score at a fixed
// rate of BONUS_PTS points every TICK_DIV cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : score_ctl_if slave modport
//     in  : add_en/add_val, level_done/bonus_time, game_over, game_clr
//     out : score, hiscore, bonus_left, bonus_busy, bonus_done
module score_ctl #(
  parameter int unsigned TICK_DIV  = 650000,
  parameter int unsigned BONUS_PTS = 10,
  parameter int unsigned MAX_SCORE = score_pkg::MAX_SCORE
) (
  input logic        clk,
  input logic        rst_n,
  score_ctl_if.slave bus
);
  import score_pkg::*;

  state_t             state_reg, state_next;
  logic [7:0]         left_reg, left_next;
  logic               done_reg, done_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [SCORE_W-1:0] hiscore_reg, hiscore_next;
  logic [SUM_W-1:0]   sum;
  logic               busy;
  logic               tick;
  logic               step;

  assign busy = (state_reg == ST_BONUS);

  // The timer only runs in BONUS, so it is always zero on BONUS entry.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .clr   (bus.game_clr),
    .tick  (tick)
  );

  assign step = tick && !bus.game_clr;

  // Next-state / outputs of the bonus FSM.
  always_comb begin
    state_next = state_reg;
    left_next  = left_reg;
    done_next  = 1'b0;
    if (bus.game_clr) begin
      state_next = ST_IDLE;
      left_next  = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.level_done) begin
            if (bus.bonus_time != 8'd0) begin
              state_next = ST_BONUS;
              left_next  = bus.bonus_time;
            end else begin
              // Nothing to transfer: report completion right away.
              done_next = 1'b1;
            end
          end
        end
        ST_BONUS: begin
          // level_done is deliberately ignored here.
          if (step) begin
            left_next = left_reg - 8'd1;
            if (left_reg == 8'd1) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Add and bonus step merge into one update; the extra sum bit keeps the
  // clamp correct even when both land near the ceiling.
  always_comb begin
    sum = {1'b0, score_reg}
        + (bus.add_en ? SUM_W'(bus.add_val) : '0)
        + (step ? SUM_W'(BONUS_PTS) : '0);
    if (bus.game_clr) begin
      score_next = '0;
    end else if (sum > SUM_W'(MAX_SCORE)) begin
      score_next = SCORE_W'(MAX_SCORE);
    end else begin
      score_next = sum[SCORE_W-1:0];
    end
  end

  // Commit uses the registered score, so a same-cycle add or clear does
  // not affect what is compared against the high score.
  always_comb begin
    hiscore_next = hiscore_reg;
    if (bus.game_over && (score_reg > hiscore_reg)) begin
      hiscore_next = score_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      left_reg    <= '0;
      done_reg    <= 1'b0;
      score_reg   <= '0;
      hiscore_reg <= '0;
    end else begin
      state_reg   <= state_next;
      left_reg    <= left_next;
      done_reg    <= done_next;
      score_reg   <= score_next;
      hiscore_reg <= hiscore_next;
    end
  end

  assign bus.score      = score_reg;
  assign bus.hiscore    = hiscore_reg;
  assign bus.bonus_left = left_reg;
  assign bus.bonus_busy = busy;
  assign bus.bonus_done = done_reg;

endmodule

// File: tb/tb_score_ctl.sv
// Directed self-checking bench for score_ctl with TICK_DIV=4, BONUS_PTS=10.
module tb_score_ctl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   done_cnt;

  score_ctl_if bus ();

  score_ctl #(
    .TICK_DIV  (4),
    .BONUS_PTS (10),
    .MAX_SCORE (999999)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] v);
    bus.add_en  = 1'b1;
    bus.add_val = v;
    cyc();
    bus.add_en  = 1'b0;
    bus.add_val = '0;
  endtask

  task automatic clr();
    bus.game_clr = 1'b1;
    cyc();
    bus.game_clr = 1'b0;
  endtask

  task automatic lvl(input logic [7:0] t);
    bus.level_done = 1'b1;
    bus.bonus_time = t;
    cyc();
    bus.level_done = 1'b0;
    bus.bonus_time = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    rst_n          = 1'b0;
    bus.add_en     = 1'b0;
    bus.add_val    = '0;
    bus.level_done = 1'b0;
    bus.bonus_time = '0;
    bus.game_over  = 1'b0;
    bus.game_clr   = 1'b0;

    // Reset state
    #12;
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_hiscore", 32'(bus.hiscore), 0);
    chk("rst_left", 32'(bus.bonus_left), 0);
    chk("rst_busy", 32'(bus.bonus_busy), 0);
    chk("rst_done", 32'(bus.bonus_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Three adds of 250
    add(16'd250);
    chk("add1_score", 32'(bus.score), 250);
    add(16'd250);
    add(16'd250);
    chk("add3_score", 32'(bus.score), 750);
    chk("add3_hiscore", 32'(bus.hiscore), 0);

    // Saturation at the ceiling
    clr();
    chk("clr_score", 32'(bus.score), 0);
    for (int i = 0; i < 15; i++) add(16'd65535);
    add(16'd16965);
    chk("pre_sat_score", 32'(bus.score), 999990);
    add(16'd65535);
    chk("sat_score", 32'(bus.score), 999999);
    add(16'd1);
    chk("sat_hold", 32'(bus.score), 999999);
    clr();
    chk("clr_keeps_hiscore", 32'(bus.hiscore), 0);

    // Bonus transfer: 3 units from score 100, step every 4 cycles
    add(16'd100);
    lvl(8'd3);
    chk("bonus_enter_busy", 32'(bus.bonus_busy), 1);
    chk("bonus_enter_left", 32'(bus.bonus_left), 3);
    done_cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) begin
        bus.level_done = 1'b1;  // must be ignored mid-transfer
        bus.bonus_time = 8'd9;
      end
      cyc();
      bus.level_done = 1'b0;
      bus.bonus_time = '0;
      if (bus.bonus_done) done_cnt++;
      if (i == 3)  chk("bonus_pre_step", 32'(bus.score), 100);
      if (i == 4)  chk("bonus_s1_score", 32'(bus.score), 110);
      if (i == 4)  chk("bonus_s1_left", 32'(bus.bonus_left), 2);
      if (i == 5)  chk("bonus_ignore_lvl", 32'(bus.bonus_left), 2);
      if (i == 8)  chk("bonus_s2_score", 32'(bus.score), 120);
      if (i == 8)  chk("bonus_s2_left", 32'(bus.bonus_left), 1);
      if (i == 11) chk("bonus_no_early_done", 32'(bus.bonus_done), 0);
      if (i == 12) chk("bonus_s3_score", 32'(bus.score), 130);
      if (i == 12) chk("bonus_s3_left", 32'(bus.bonus_left), 0);
      if (i == 12) chk("bonus_done_pulse", 32'(bus.bonus_done), 1);
      if (i == 12) chk("bonus_idle_busy", 32'(bus.bonus_busy), 0);
    end
    chk("bonus_done_count", 32'(done_cnt), 1);
    chk("bonus_final_score", 32'(bus.score), 130);

    // Zero bonus time: immediate done pulse, no BONUS state
    lvl(8'd0);
    chk("zero_done", 32'(bus.bonus_done), 1);
    chk("zero_busy", 32'(bus.bonus_busy), 0);
    cyc();
    chk("zero_done_end", 32'(bus.bonus_done), 0);

    // Add coincident with a bonus step: +15 in one cycle
    lvl(8'd2);
    cyc();
    cyc();
    cyc();
    chk("merge_pre", 32'(bus.score), 130);
    add(16'd5);
    chk("merge_score", 32'(bus.score), 145);
    for (int i = 0; i < 5; i++) cyc();
    chk("merge_final", 32'(bus.score), 155);
    chk("merge_busy", 32'(bus.bonus_busy), 0);

    // High score with game_over / game_clr interplay
    clr();
    add(16'd300);
    bus.game_over = 1'b1;
    cyc();
    bus.game_over = 1'b0;
    chk("hi_300", 32'(bus.hiscore), 300);
    clr();
    add(16'd500);
    bus.game_over = 1'b1;
    bus.game_clr  = 1'b1;
    cyc();
    bus.game_over = 1'b0;
    bus.game_clr  = 1'b0;
    chk("hi_over_clr", 32'(bus.hiscore), 500);
    chk("score_over_clr", 32'(bus.score), 0);
    bus.game_over = 1'b1;
    cyc();
    bus.game_over = 1'b0;
    chk("hi_keep", 32'(bus.hiscore), 500);
    bus.game_over = 1'b1;
    add(16'd600);
    bus.game_over = 1'b0;
    chk("hi_preupdate", 32'(bus.hiscore), 500);
    chk("score_with_over", 32'(bus.score), 600);
    bus.game_over = 1'b1;
    cyc();
    bus.game_over = 1'b0;
    chk("hi_600", 32'(bus.hiscore), 600);

    // Reset in the middle of a transfer
    lvl(8'd5);
    for (int i = 0; i < 6; i++) cyc();
    chk("mid_busy", 32'(bus.bonus_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_score", 32'(bus.score), 0);
    chk("arst_hiscore", 32'(bus.hiscore), 0);
    chk("arst_left", 32'(bus.bonus_left), 0);
    chk("arst_busy", 32'(bus.bonus_busy), 0);
    chk("arst_done", 32'(bus.bonus_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.bonus_done) done_cnt++;
    end
    chk("arst_no_done", 32'(done_cnt), 0);
    chk("arst_idle", 32'(bus.bonus_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_ctl.md
SCORE_CTL -- requirements
Module: score_ctl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 650000; clk cycles per bonus-transfer step, minimum 1.
REQ-002 SHALL have parameter BONUS_PTS, default 10; points added per bonus step.
REQ-003 SHALL have parameter MAX_SCORE, default 999999; saturation ceiling, the largest value representable in 6 BCD digits.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port add_en  in  1  one-cycle strobe: add add_val to score.
REQ-007 SHALL have port add_val  in  16  points to add, unsigned.
REQ-008 SHALL have port level_done  in  1  one-cycle strobe: start the time-bonus transfer.
REQ-009 SHALL have port bonus_time  in  8  remaining time units, sampled on level_done.
REQ-010 SHALL have port game_over  in  1  one-cycle strobe: commit score to the high score.
REQ-011 SHALL have port game_clr  in  1  synchronous clear of the game state.
REQ-012 SHALL have port score  out  24  current score, binary; feeds the binary-to-BCD display stage.
REQ-013 SHALL have port hiscore  out  24  high score, binary.
REQ-014 SHALL have port bonus_left  out  8  time units not yet transferred.
REQ-015 SHALL have port bonus_busy  out  1  high in state BONUS.
REQ-016 SHALL have port bonus_done  out  1  one-cycle pulse at the end of a transfer.

Function
REQ-017 SHALL implement FSM states IDLE and BONUS; IDLE->BONUS on level_done when bonus_time!=0; BONUS->IDLE on the step that takes bonus_left to 0.
REQ-018 SHALL, on level_done in IDLE with bonus_time==0, stay in IDLE and pulse bonus_done on the next cycle.
REQ-019 SHALL ignore level_done while in BONUS.
REQ-020 SHALL, on entering BONUS, load bonus_left=bonus_time and clear the tick counter; a step occurs when TICK_DIV cycles have elapsed in BONUS.
REQ-021 SHALL, on each step, add BONUS_PTS to score and decrement bonus_left by 1, both visible in the following cycle.
REQ-022 SHALL assert bonus_done for exactly one cycle, coincident with the first IDLE cycle after the final step.
REQ-023 SHALL compute the next score as score + (add_en?add_val:0) + (step?BONUS_PTS:0) at 25-bit width, clamped to MAX_SCORE; latency is 1 cycle.
REQ-024 SHALL accumulate add_en and a step in the same cycle into a single update.
REQ-025 SHALL hold score at MAX_SCORE once reached, until game_clr or reset; it SHALL never wrap.
REQ-026 SHALL, on game_over, set hiscore=score when the registered pre-update score exceeds hiscore; an add in the same cycle updates score only.
REQ-027 SHALL, on game_clr, set score=0, bonus_left=0, state=IDLE, and tick counter=0, with bonus_done low; game_clr has priority over add_en, level_done and steps.
REQ-028 SHALL keep hiscore unchanged on game_clr.
REQ-029 SHALL, on game_over together with game_clr, commit the pre-clear score to hiscore before clearing.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set score=0, hiscore=0, bonus_left=0, bonus_busy=0, bonus_done=0, state=IDLE, and tick counter=0.
REQ-031 SHALL, on reset mid-BONUS, abandon the transfer without emitting bonus_done.

Structure
REQ-032 SHALL define SCORE_W=24, MAX_SCORE and the FSM state encodings in the shared package score_pkg.
REQ-033 SHALL instantiate sub-module tick_gen (a counter with enable and sync clear, parameter TICK_DIV, producing a one-cycle tick); all other logic is local.

Verification
REQ-034 SHALL cover: reset, then add_en with add_val=250 three times -> score=750 one cycle after the third strobe, hiscore=0.
REQ-035 SHALL cover: score=999990 and add_en with add_val=65535 -> score=999999; a further add_en with add_val=1 -> score stays 999999.
REQ-036 SHALL cover, with TICK_DIV=4 and BONUS_PTS=10: level_done with bonus_time=3 from score 100 -> score 110/120/130 at 4-cycle spacing; bonus_left 2/1/0; one bonus_done pulse; bonus_busy low afterwards.
REQ-037 SHALL cover, during BONUS: add_en with add_val=5 in the same cycle as a step -> score rises by 15 in a single cycle.
REQ-038 SHALL cover: score=500, hiscore=300, game_over together with game_clr -> hiscore=500 and score=0; a following game_over at score=0 -> hiscore stays 500.
REQ-039 SHALL cover: rst_n pulsed low mid-BONUS -> all outputs 0 immediately, and no bonus_done afterwards.
